// File: rtl/mem_arbiter_if.sv
// Bus bundle between the cache requesters, the memory port and mem_arbiter.
// master = caches + memory side, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int TAG_W   = 4,
  parameter int ADDR_W  = 32,
  parameter int BLOCK_W = 64
);
  logic               i_req_valid;
  logic [ADDR_W-1:0]  i_req_addr;
  logic               i_req_accepted;
  logic               d_req_valid;
  logic               d_req_store;
  logic [ADDR_W-1:0]  d_req_addr;
  logic [BLOCK_W-1:0] d_req_data;
  logic               d_req_accepted;
  logic [TAG_W-1:0]   req_tag;
  logic [1:0]         mem_command;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [TAG_W-1:0]   mem_resp_tag;
  logic [BLOCK_W-1:0] mem_data;
  logic [TAG_W-1:0]   mem_data_tag;
  logic [TAG_W-1:0]   i_rsp_tag;
  logic [TAG_W-1:0]   d_rsp_tag;
  logic [BLOCK_W-1:0] rsp_data;
  logic [TAG_W-1:0]   i_outstanding;
  logic [TAG_W-1:0]   d_outstanding;
  logic               stray_tag_err;

  modport master (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_store,
    output d_req_addr, d_req_data,
    output mem_resp_tag, mem_data,
    output mem_data_tag,
    input  i_req_accepted, d_req_accepted,
    input  req_tag, mem_command,
    input  mem_addr, mem_wdata,
    input  i_rsp_tag, d_rsp_tag,
    input  rsp_data, i_outstanding,
    input  d_outstanding, stray_tag_err
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_store,
    input  d_req_addr, d_req_data,
    input  mem_resp_tag, mem_data,
    input  mem_data_tag,
    output i_req_accepted, d_req_accepted,
    output req_tag, mem_command,
    output mem_addr, mem_wdata,
    output i_rsp_tag, d_rsp_tag,
    output rsp_data, i_outstanding,
    output d_outstanding, stray_tag_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory port arbiter between icache and dcache with an
// anti-starvation priority FSM and a tag-ownership table.
module mem_arbiter #(
  parameter int NUM_TAGS     = 15,
  parameter int TAG_W        = 4,
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clock,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX =
    CNT_W'(STARVE_LIMIT);
  localparam logic [TAG_W-1:0] MAX_TAG =
    TAG_W'(NUM_TAGS);
  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {PRIO_D, PRIO_I} prio_e;

  prio_e              r_state;
  logic [CNT_W-1:0]   r_starve;
  logic [NUM_TAGS-1:0] r_tv;
  logic [NUM_TAGS-1:0] r_town;
  logic [TAG_W-1:0]   r_iout;
  logic [TAG_W-1:0]   r_dout;
  logic               r_stray;

  logic             w_gnt_i;
  logic             w_gnt_d;
  logic             w_rt_nz;
  logic             w_rt_ok;
  logic             w_acc_i;
  logic             w_acc_d;
  logic             w_alloc_i;
  logic             w_alloc_d;
  logic             w_dt_nz;
  logic             w_dt_ok;
  logic             w_hit;
  logic             w_ret_i;
  logic             w_ret_d;
  logic [TAG_W-1:0] w_aidx;
  logic [TAG_W-1:0] w_didx;
  logic [CNT_W-1:0] w_starve_nxt;

  assign w_gnt_i = bus.i_req_valid &&
    (!bus.d_req_valid || r_state == PRIO_I);
  assign w_gnt_d = bus.d_req_valid && !w_gnt_i;

  always_comb begin
    bus.mem_command = CMD_NONE;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    unique case (1'b1)
      w_gnt_i: begin
        bus.mem_command = CMD_LOAD;
        bus.mem_addr    = bus.i_req_addr;
      end
      w_gnt_d: begin
        bus.mem_command = bus.d_req_store ?
          CMD_STORE : CMD_LOAD;
        bus.mem_addr    = bus.d_req_addr;
        bus.mem_wdata   = bus.d_req_data;
      end
      default: ;
    endcase
  end

  assign w_rt_nz = |bus.mem_resp_tag;
  assign w_rt_ok = w_rt_nz &&
    (bus.mem_resp_tag <= MAX_TAG);
  assign w_acc_i = w_gnt_i && w_rt_nz;
  assign w_acc_d = w_gnt_d && w_rt_nz;
  assign bus.i_req_accepted = w_acc_i;
  assign bus.d_req_accepted = w_acc_d;
  assign bus.req_tag =
    (w_acc_i || w_acc_d) ? bus.mem_resp_tag : '0;

  assign w_alloc_i = w_acc_i && w_rt_ok;
  assign w_alloc_d = w_acc_d && w_rt_ok &&
    !bus.d_req_store;

  assign w_aidx  = bus.mem_resp_tag - TAG_W'(1);
  assign w_didx  = bus.mem_data_tag - TAG_W'(1);
  assign w_dt_nz = |bus.mem_data_tag;
  assign w_dt_ok = w_dt_nz &&
    (bus.mem_data_tag <= MAX_TAG);
  assign w_hit   = w_dt_ok && r_tv[w_didx];
  assign w_ret_i = w_hit && !r_town[w_didx];
  assign w_ret_d = w_hit && r_town[w_didx];

  assign bus.i_rsp_tag =
    w_ret_i ? bus.mem_data_tag : '0;
  assign bus.d_rsp_tag =
    w_ret_d ? bus.mem_data_tag : '0;
  assign bus.rsp_data      = bus.mem_data;
  assign bus.i_outstanding = r_iout;
  assign bus.d_outstanding = r_dout;
  assign bus.stray_tag_err = r_stray;

  always_comb begin
    w_starve_nxt = r_starve;
    if (!bus.i_req_valid || w_acc_i)
      w_starve_nxt = '0;
    else if (r_starve != STARVE_MAX)
      w_starve_nxt = r_starve + CNT_W'(1);
  end

  // Entering PRIO_I on the next-count lets the icache win the cycle
  // right after its last lost cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= PRIO_D;
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      unique case (r_state)
        PRIO_D:
          if (w_starve_nxt == STARVE_MAX)
            r_state <= PRIO_I;
        PRIO_I:
          if (w_acc_i || !bus.i_req_valid)
            r_state <= PRIO_D;
        default: r_state <= PRIO_D;
      endcase
    end
  end

  // Allocation is written after the return clear so a same-cycle
  // reuse of a tag ends up owned by the new requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tv    <= '0;
      r_town  <= '0;
      r_iout  <= '0;
      r_dout  <= '0;
      r_stray <= 1'b0;
    end else begin
      if (w_hit)
        r_tv[w_didx] <= 1'b0;
      if (w_alloc_i || w_alloc_d) begin
        r_tv[w_aidx]   <= 1'b1;
        r_town[w_aidx] <= w_alloc_d;
      end
      if (w_dt_nz && !w_hit)
        r_stray <= 1'b1;
      r_iout <= r_iout + TAG_W'(w_alloc_i)
                - TAG_W'(w_ret_i);
      r_dout <= r_dout + TAG_W'(w_alloc_d)
                - TAG_W'(w_ret_d);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vectors, corner
// sequences and a randomized run against a reference model.
module tb_mem_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_arbiter_if bus ();
  mem_arbiter dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        ds;
    logic [31:0] da;
    logic [63:0] dd;
    logic [3:0]  rt;
    logic [3:0]  dt;
    logic [63:0] md;
  } in_t;

  typedef struct {
    in_t         in;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [63:0] wd;
    logic        ia;
    logic        da;
    logic [3:0]  tag;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic in_t mk_in(
    logic iv, logic [31:0] ia, logic dv,
    logic ds, logic [31:0] da,
    logic [63:0] dd, logic [3:0] rt);
    in_t x;
    x.iv = iv; x.ia = ia; x.dv = dv;
    x.ds = ds; x.da = da; x.dd = dd;
    x.rt = rt; x.dt = '0; x.md = '0;
    return x;
  endfunction

  function automatic vec_t mkv(
    in_t in, logic [1:0] cmd,
    logic [31:0] addr, logic [63:0] wd,
    logic ia, logic da, logic [3:0] tag);
    vec_t v;
    v.in = in; v.cmd = cmd; v.addr = addr;
    v.wd = wd; v.ia = ia; v.da = da;
    v.tag = tag;
    return v;
  endfunction

  task automatic apply(input in_t x);
    bus.i_req_valid  = x.iv;
    bus.i_req_addr   = x.ia;
    bus.d_req_valid  = x.dv;
    bus.d_req_store  = x.ds;
    bus.d_req_addr   = x.da;
    bus.d_req_data   = x.dd;
    bus.mem_resp_tag = x.rt;
    bus.mem_data_tag = x.dt;
    bus.mem_data     = x.md;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    tick();
    reset = 1'b0;
  endtask

  vec_t vt[8];
  in_t  x;
  int   own[16];
  int   streak;
  bit   stray_m;
  int   q[$];
  int   win;
  bit   acc;
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_wd;
  logic [3:0]  e_ir;
  logic [3:0]  e_dr;
  int   e_io;
  int   e_do;

  initial begin
    vt[0] = mkv(mk_in(0, 0, 0, 0, 0, 0, 0),
                0, 0, 0, 0, 0, 0);
    vt[1] = mkv(mk_in(1, 'h100, 0, 0, 0, 0, 3),
                1, 'h100, 0, 1, 0, 3);
    vt[2] = mkv(mk_in(0, 0, 1, 0, 'h200, 'h55, 5),
                1, 'h200, 'h55, 0, 1, 5);
    vt[3] = mkv(mk_in(1, 'h100, 1, 0, 'h200, 0, 5),
                1, 'h200, 0, 0, 1, 5);
    vt[4] = mkv(mk_in(0, 0, 1, 1, 'h300, 'hDEAD, 7),
                2, 'h300, 'hDEAD, 0, 1, 7);
    vt[5] = mkv(mk_in(1, 'h140, 0, 0, 0, 0, 0),
                1, 'h140, 0, 0, 0, 0);
    vt[6] = mkv(mk_in(1, 'h180, 1, 1, 'h340,
                      'hBEEF, 0),
                2, 'h340, 'hBEEF, 0, 0, 0);
    vt[7] = mkv(mk_in(0, 'h1c0, 0, 1, 'h380,
                      'h1234, 9),
                0, 0, 0, 0, 0, 0);

    do_reset();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rst_cmd", bus.mem_command, 0);
    chk("rst_tag", bus.req_tag, 0);
    chk("rst_iout", bus.i_outstanding, 0);
    chk("rst_dout", bus.d_outstanding, 0);
    chk("rst_stray", bus.stray_tag_err, 0);
    chk("rst_irsp", bus.i_rsp_tag, 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      apply(vt[i].in);
      #1;
      chk($sformatf("v%0d_cmd", i),
          bus.mem_command, vt[i].cmd);
      chk($sformatf("v%0d_addr", i),
          bus.mem_addr, vt[i].addr);
      chk($sformatf("v%0d_wd", i),
          bus.mem_wdata, vt[i].wd);
      chk($sformatf("v%0d_ia", i),
          bus.i_req_accepted, vt[i].ia);
      chk($sformatf("v%0d_da", i),
          bus.d_req_accepted, vt[i].da);
      chk($sformatf("v%0d_tag", i),
          bus.req_tag, vt[i].tag);
    end

    // idle then load, return to icache
    do_reset();
    apply(mk_in(1, 'h100, 0, 0, 0, 0, 3));
    #1;
    chk("A_iacc", bus.i_req_accepted, 1);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("A_iout1", bus.i_outstanding, 1);
    x = mk_in(0, 0, 0, 0, 0, 0, 0);
    x.dt = 3;
    x.md = 64'hCAFE_F00D_1234_5678;
    apply(x);
    #1;
    chk("A_irsp", bus.i_rsp_tag, 3);
    chk("A_drsp", bus.d_rsp_tag, 0);
    chk("A_data", bus.rsp_data,
        64'hCAFE_F00D_1234_5678);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("A_iout0", bus.i_outstanding, 0);
    chk("A_stray", bus.stray_tag_err, 0);

    // starvation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      apply(mk_in(1, 'h100, 1, 0, 'h200,
                  0, 4'(k + 1)));
      #1;
      chk($sformatf("B_dwin%0d", k),
          bus.d_req_accepted, 1);
      chk($sformatf("B_ilose%0d", k),
          bus.i_req_accepted, 0);
      tick();
    end
    apply(mk_in(1, 'h100, 1, 0, 'h200, 0, 9));
    #1;
    chk("B_iwin", bus.i_req_accepted, 1);
    chk("B_dlose", bus.d_req_accepted, 0);
    chk("B_addr", bus.mem_addr, 'h100);
    tick();
    apply(mk_in(1, 'h104, 1, 0, 'h210, 0, 10));
    #1;
    chk("B_dback", bus.d_req_accepted, 1);
    chk("B_iback", bus.i_req_accepted, 0);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("B_dout", bus.d_outstanding, 5);
    chk("B_iout", bus.i_outstanding, 1);

    // store then stray return
    do_reset();
    apply(mk_in(0, 0, 1, 1, 'h300, 'hDEAD, 7));
    #1;
    chk("C_cmd", bus.mem_command, 2);
    chk("C_wd", bus.mem_wdata, 'hDEAD);
    tick();
    x = mk_in(0, 0, 0, 0, 0, 0, 0);
    x.dt = 7;
    apply(x);
    #1;
    chk("C_dout", bus.d_outstanding, 0);
    chk("C_irsp", bus.i_rsp_tag, 0);
    chk("C_drsp", bus.d_rsp_tag, 0);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    tick();
    tick();
    chk("C_stray", bus.stray_tag_err, 1);

    // rejection, retry and same-cycle tag reuse
    do_reset();
    apply(mk_in(1, 'h100, 0, 0, 0, 0, 0));
    #1;
    chk("D_rej", bus.i_req_accepted, 0);
    chk("D_rejtag", bus.req_tag, 0);
    tick();
    apply(mk_in(1, 'h100, 0, 0, 0, 0, 2));
    #1;
    chk("D_retry", bus.i_req_accepted, 1);
    tick();
    x = mk_in(0, 0, 1, 0, 'h200, 0, 2);
    x.dt = 2;
    apply(x);
    #1;
    chk("D_irsp", bus.i_rsp_tag, 2);
    chk("D_drsp", bus.d_rsp_tag, 0);
    chk("D_dacc", bus.d_req_accepted, 1);
    tick();
    x = mk_in(0, 0, 0, 0, 0, 0, 0);
    apply(x);
    #1;
    chk("D_iout", bus.i_outstanding, 0);
    chk("D_dout1", bus.d_outstanding, 1);
    x.dt = 2;
    apply(x);
    #1;
    chk("D_drsp2", bus.d_rsp_tag, 2);
    chk("D_irsp2", bus.i_rsp_tag, 0);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("D_dout0", bus.d_outstanding, 0);
    chk("D_stray", bus.stray_tag_err, 0);

    // reset mid-flight with icache holding priority
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      apply(mk_in(1, 'h100, 0, 0, 0, 0, 4'(k)));
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      apply(mk_in(1, 'h100, 1, 1, 'h200, 0, 8));
      tick();
    end
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("E_iout3", bus.i_outstanding, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("E_iout0", bus.i_outstanding, 0);
    chk("E_dout0", bus.d_outstanding, 0);
    apply(mk_in(1, 'h100, 1, 0, 'h200, 0, 4));
    #1;
    chk("E_prio_d", bus.d_req_accepted, 1);
    x = mk_in(0, 0, 0, 0, 0, 0, 0);
    x.dt = 1;
    apply(x);
    #1;
    chk("E_irsp", bus.i_rsp_tag, 0);
    tick();
    apply(mk_in(0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("E_stray", bus.stray_tag_err, 1);

    // randomized run against the reference model
    do_reset();
    for (int t = 0; t < 16; t++) own[t] = -1;
    streak  = 0;
    stray_m = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
        for (int t = 0; t < 16; t++) own[t] = -1;
        streak  = 0;
        stray_m = 0;
        continue;
      end
      x.iv = ($urandom_range(3) != 0);
      x.ia = $urandom;
      x.dv = ($urandom_range(3) != 0);
      x.ds = ($urandom_range(2) == 0);
      x.da = $urandom;
      x.dd = {$urandom, $urandom};
      x.md = {$urandom, $urandom};
      q.delete();
      for (int t = 1; t < 16; t++)
        if (own[t] >= 0) q.push_back(t);
      x.dt = 0;
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5:
          if (q.size() > 0)
            x.dt = 4'(q[$urandom_range(q.size() - 1)]);
        6: x.dt = 4'($urandom_range(15));
        default: ;
      endcase
      q.delete();
      for (int t = 1; t < 16; t++)
        if (own[t] < 0 || t == int'(x.dt))
          q.push_back(t);
      x.rt = 0;
      if ($urandom_range(6) != 0 && q.size() > 0)
        x.rt = 4'(q[$urandom_range(q.size() - 1)]);
      apply(x);
      #1;

      if (x.iv && x.dv) win = (streak >= 4) ? 1 : 2;
      else if (x.iv)    win = 1;
      else if (x.dv)    win = 2;
      else              win = 0;
      acc    = (win != 0) && (x.rt != 0);
      e_cmd  = (win == 1) ? 2'd1 :
               (win == 2) ? (x.ds ? 2'd2 : 2'd1) : 2'd0;
      e_addr = (win == 1) ? x.ia :
               (win == 2) ? x.da : 32'd0;
      e_wd   = (win == 2) ? x.dd : 64'd0;
      e_ir   = (x.dt != 0 && own[x.dt] == 0) ? x.dt : 4'd0;
      e_dr   = (x.dt != 0 && own[x.dt] == 1) ? x.dt : 4'd0;
      e_io = 0;
      e_do = 0;
      for (int t = 1; t < 16; t++) begin
        if (own[t] == 0) e_io++;
        if (own[t] == 1) e_do++;
      end

      chk("rnd_cmd", bus.mem_command, e_cmd);
      chk("rnd_addr", bus.mem_addr, e_addr);
      chk("rnd_wd", bus.mem_wdata, e_wd);
      chk("rnd_ia", bus.i_req_accepted,
          acc && win == 1);
      chk("rnd_da", bus.d_req_accepted,
          acc && win == 2);
      chk("rnd_tag", bus.req_tag,
          acc ? x.rt : 4'd0);
      chk("rnd_irsp", bus.i_rsp_tag, e_ir);
      chk("rnd_drsp", bus.d_rsp_tag, e_dr);
      chk("rnd_data", bus.rsp_data, x.md);
      chk("rnd_iout", bus.i_outstanding, e_io);
      chk("rnd_dout", bus.d_outstanding, e_do);
      chk("rnd_stray", bus.stray_tag_err, stray_m);
      tick();

      if (x.dt != 0) begin
        if (own[x.dt] >= 0) own[x.dt] = -1;
        else stray_m = 1;
      end
      if (acc && !(win == 2 && x.ds))
        own[x.rt] = (win == 1) ? 0 : 1;
      if (x.iv && !(acc && win == 1))
        streak = (streak < 100) ? streak + 1 : streak;
      else
        streak = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the icache subsystem (instruction fetch/prefetch loads) and the dcache (data loads and store writebacks).
- Picks one requester per cycle and drives the memory command bus.
- Reports acceptance and the memory transaction tag back to the winner.
- Keeps a tag-ownership table so returned data is steered only to the requester that issued the load.

Parameters:
NUM_TAGS, 15, number of nonzero memory transaction tags; tag 0 means "no tag / rejected"
TAG_W, 4, width of a tag, equal to clog2(NUM_TAGS+1)
ADDR_W, 32, memory address width
BLOCK_W, 64, memory block width
STARVE_LIMIT, 4, consecutive lost cycles after which the icache is given priority

Ports:
clock  in  1  system clock
reset  in  1  reset, synchronous, active-high
i_req_valid  in  1  icache load request
i_req_addr  in  ADDR_W  icache block address
i_req_accepted  out  1  icache request taken by memory this cycle
d_req_valid  in  1  dcache request
d_req_store  in  1  1 = store, 0 = load
d_req_addr  in  ADDR_W  dcache block address
d_req_data  in  BLOCK_W  store data
d_req_accepted  out  1  dcache request taken by memory this cycle
req_tag  out  TAG_W  tag of the accepted request; 0 if none
mem_command  out  2  0 = NONE, 1 = LOAD, 2 = STORE
mem_addr  out  ADDR_W  address to memory
mem_wdata  out  BLOCK_W  store data to memory
mem_resp_tag  in  TAG_W  same-cycle acceptance tag from memory; 0 = rejected
mem_data  in  BLOCK_W  returned block
mem_data_tag  in  TAG_W  tag of the returned block; 0 = none
i_rsp_tag  out  TAG_W  mem_data_tag if owned by icache, else 0
d_rsp_tag  out  TAG_W  mem_data_tag if owned by dcache, else 0
rsp_data  out  BLOCK_W  mem_data passed through
i_outstanding  out  TAG_W  icache loads in flight
d_outstanding  out  TAG_W  dcache loads in flight
stray_tag_err  out  1  sticky: a data return arrived with an unmapped tag

Behaviour:
- Grant is combinational. The cycle's winner drives mem_command, mem_addr and mem_wdata. With no request, all three are 0.
- Acceptance: winner's *_req_accepted = (mem_resp_tag != 0), asserted the same cycle. req_tag = mem_resp_tag when accepted, else 0. The loser's accepted signal is 0.
- A rejected request is not queued. The requester holds valid, and the arbiter re-arbitrates next cycle.
- Priority FSM has two states:
  - PRIO_D (reset state): dcache wins on conflict.
  - PRIO_I: icache wins on conflict.
- Starve counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle i_req_valid is high and the icache is not accepted.
  - Clears when i_req_accepted or when !i_req_valid.
  - Saturates at STARVE_LIMIT.
- FSM transitions:
  - PRIO_D -> PRIO_I when the counter reaches STARVE_LIMIT; priority takes effect the following cycle.
  - PRIO_I -> PRIO_D on the cycle after i_req_accepted.
  - PRIO_I -> PRIO_D if i_req_valid drops.
- Owner table: NUM_TAGS entries {valid, owner}, indexed by tag-1.
  - An accepted LOAD sets entry[req_tag] = {1, owner}.
  - An accepted STORE allocates nothing.
- Return routing, when mem_data_tag != 0:
  - If the entry is valid: drive the owner's *_rsp_tag = mem_data_tag and clear the entry next edge.
  - If the entry is invalid: both rsp tags are 0, and stray_tag_err is set, held until reset.
- Same-cycle return and allocate of the same tag: routing uses the pre-edge entry, and the new allocation wins at the edge (entry ends valid with the new owner).
- Outstanding counters:
  - +1 on the owner's accepted load, -1 on the owner's routed return. Both in one cycle leaves the count unchanged.
  - The counters never wrap, since memory cannot issue more than NUM_TAGS live tags.
- rsp_data = mem_data, combinational pass-through.
- Reset values:
  - Outputs: all 0. mem_command = NONE.
  - State: FSM = PRIO_D, starve counter 0, table cleared, stray_tag_err 0.
  - A reset mid-flight discards ownership. Returns arriving after reset are treated as stray.

Test Plan:
- Idle-then-load: i_req_valid=1, addr 0x100, mem_resp_tag=3 -> same cycle mem_command=1, i_req_accepted=1, req_tag=3. Later mem_data_tag=3 -> i_rsp_tag=3, d_rsp_tag=0, i_outstanding 1->0.
- Conflict: both valid, d load 0x200, mem_resp_tag=5 -> dcache wins, d_req_accepted=1, i_req_accepted=0, mem_addr=0x200. A return with tag 5 goes to d_rsp_tag.
- Starvation: both valid for 4 cycles with the dcache accepted each cycle -> cycle 5 FSM=PRIO_I and icache wins. After icache acceptance, priority returns to the dcache on the next cycle.
- Store: d_req_store=1, data 0xDEAD, mem_resp_tag=7 -> mem_command=2, mem_wdata=0xDEAD, d_outstanding unchanged. A later mem_data_tag=7 -> stray_tag_err=1, both rsp tags 0.
- Rejection and tag reuse: mem_resp_tag=0 -> no accept, and the request is re-presented next cycle. Return of tag 2 (icache) in the same cycle as a dcache load accepted with tag 2 -> i_rsp_tag=2 that cycle; the entry becomes dcache-owned.
- Reset mid-flight: 3 loads in flight, assert reset -> counters 0, FSM PRIO_D. A subsequent return with tag 1 -> stray_tag_err=1.
